// File: rtl/meas_point_fifo.sv
// Measurement-point FIFO: captures ch1/ch2 points through per-channel pending
// registers into a shared FIFO, drained by software over a 4-register Wishbone window.

module meas_point_pend #(
    parameter int PW = 26
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush,
    input  logic          rdy,
    input  logic          grant,
    input  logic [PW-1:0] pt,
    output logic          full,
    output logic [PW-1:0] data,
    output logic          drop
);
    // A grant frees the slot this cycle, so a same-cycle arrival still loads.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush) begin
            full <= 1'b0;
            data <= '0;
        end else if (rdy && (!full || grant)) begin
            full <= 1'b1;
            data <= pt;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

    assign drop = rdy & full & ~grant & ~flush;
endmodule

module meas_point_fifo #(
    parameter int DEPTH        = 16,
    parameter int D_CODE_WIDTH = 10,
    parameter int THR_WIDTH    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ch1_point_rdy_i,
    input  logic [D_CODE_WIDTH-1:0] ch1_d_code_i,
    input  logic [THR_WIDTH-1:0]    ch1_threshold_i,
    input  logic                    ch2_point_rdy_i,
    input  logic [D_CODE_WIDTH-1:0] ch2_d_code_i,
    input  logic [THR_WIDTH-1:0]    ch2_threshold_i,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    input  logic [31:0]             wb_adr_i,
    input  logic                    wb_we_i,
    input  logic [3:0]              wb_sel_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic                    wb_ack_o,
    output logic                    irq_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int PW  = D_CODE_WIDTH + THR_WIDTH;
    localparam int NCH = 2;

    logic [NCH-1:0]         rdy, pend_full, gnt, drop;
    logic [NCH-1:0][PW-1:0] pt_in, pend_data;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          ovf, empty, full, can_push, push;
    logic [PW-1:0] push_data;
    logic [31:0]   entry;

    logic [1:0]  idx;
    logic        req, ack_set, rd, pop, ctl_wr, flush, ovf_clr;
    logic [31:0] rd_data;

    assign rdy   = {ch2_point_rdy_i, ch1_point_rdy_i};
    assign pt_in = {{ch2_d_code_i, ch2_threshold_i}, {ch1_d_code_i, ch1_threshold_i}};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        meas_point_pend #(.PW(PW)) u_pend (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .flush  (flush),
            .rdy    (rdy[c]),
            .grant  (gnt[c]),
            .pt     (pt_in[c]),
            .full   (pend_full[c]),
            .data   (pend_data[c]),
            .drop   (drop[c])
        );
    end

    // Fixed priority to ch1; ch2 wins the following cycle once ch1 drains.
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign can_push = ~full & ~flush;
    assign gnt[0]   = pend_full[0] & can_push;
    assign gnt[1]   = pend_full[1] & can_push & ~pend_full[0];
    assign push     = |gnt;

    assign push_data = gnt[0] ? pend_data[0] : pend_data[1];
    assign entry     = {1'b1, ~gnt[0], 4'b0, 10'(push_data[PW-1:THR_WIDTH]),
                        16'(push_data[THR_WIDTH-1:0])};

    // Side effects fire only on the edge that raises ack.
    assign req     = wb_cyc_i & wb_stb_i;
    assign ack_set = req & ~wb_ack_o;
    assign idx     = wb_adr_i[3:2];
    assign rd      = ack_set & ~wb_we_i;
    assign pop     = rd & (idx == 2'd1) & ~empty;
    assign ctl_wr  = ack_set & wb_we_i & (idx == 2'd2) & wb_sel_i[0];
    assign flush   = ctl_wr & wb_dat_i[0];
    assign ovf_clr = ctl_wr & wb_dat_i[1];

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_comb begin
        rd_data = '0;
        case (idx)
            2'd0:    rd_data = {ovf, full, empty, 13'b0, 16'(count)};
            2'd1:    if (!empty) rd_data = mem[rd_ptr];
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            irq_o <= (count_nxt != '0);
            if (ovf_clr)
                ovf <= 1'b0;
            else if (|drop)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= ack_set;
            wb_dat_o <= rd ? rd_data : '0;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:2], wb_sel_i[3:1]};
endmodule

// File: tb/tb_meas_point_fifo.sv
// Scoreboard bench for meas_point_fifo: reads queue their expected data, a
// negedge monitor pops and compares on every ack.

module tb_meas_point_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ch1_rdy = 1'b0, ch2_rdy = 1'b0;
    logic [9:0]  ch1_d = '0, ch2_d = '0;
    logic [15:0] ch1_t = '0, ch2_t = '0;
    logic [31:0] wb_dat_i = '0, wb_adr = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
    logic [3:0]  wb_sel = 4'hF;
    logic        wb_ack_o, irq_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    meas_point_fifo dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ch1_point_rdy_i (ch1_rdy),
        .ch1_d_code_i    (ch1_d),
        .ch1_threshold_i (ch1_t),
        .ch2_point_rdy_i (ch2_rdy),
        .ch2_d_code_i    (ch2_d),
        .ch2_threshold_i (ch2_t),
        .wb_dat_i        (wb_dat_i),
        .wb_dat_o        (wb_dat_o),
        .wb_adr_i        (wb_adr),
        .wb_we_i         (wb_we),
        .wb_sel_i        (wb_sel),
        .wb_cyc_i        (wb_cyc),
        .wb_stb_i        (wb_stb),
        .wb_ack_o        (wb_ack_o),
        .irq_o           (irq_o)
    );

    always @(negedge clk) begin
        if (wb_ack_o) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack got=%h", wb_dat_o);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.chk) begin
                    checks++;
                    if (wb_dat_o !== mon_e.exp) begin
                        failures++;
                        $display("FAIL %s got=%h exp=%h", mon_e.name, wb_dat_o, mon_e.exp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] wdata,
                           input logic [31:0] exp, input string name);
        exp_t e;
        int   n;
        e.chk  = !we;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_adr   = {28'b0, idx, 2'b00};
        wb_dat_i = wdata;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_ack_o && n < 20);
        if (!wb_ack_o) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout ack=0 exp=1", name);
            q.delete(q.size() - 1);
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic pulse1(input logic [9:0] d, input logic [15:0] t);
        ch1_rdy = 1'b1;
        ch1_d   = d;
        ch1_t   = t;
        idle(1);
        ch1_rdy = 1'b0;
    endtask

    initial begin
        idle(3);
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_irq", {31'b0, irq_o}, 32'd0);
        rst_n = 1'b1;
        idle(1);
        wb_xfer(1'b0, 2'd0, 0, 32'h2000_0000, "status_reset");

        // single ch1 point
        pulse1(10'h155, 16'hA5A5);
        idle(1);
        check("irq_one", {31'b0, irq_o}, 32'd1);
        wb_xfer(1'b0, 2'd0, 0, 32'h0000_0001, "status_one");
        wb_xfer(1'b0, 2'd1, 0, 32'h8155_A5A5, "data_ch1");
        check("irq_drained", {31'b0, irq_o}, 32'd0);
        wb_xfer(1'b0, 2'd0, 0, 32'h2000_0000, "status_drained");

        // simultaneous ch1 and ch2: ch1 first
        ch1_rdy = 1'b1; ch1_d = 10'h2AA; ch1_t = 16'h1234;
        ch2_rdy = 1'b1; ch2_d = 10'h003; ch2_t = 16'h0010;
        idle(1);
        ch1_rdy = 1'b0; ch2_rdy = 1'b0;
        idle(2);
        wb_xfer(1'b0, 2'd0, 0, 32'h0000_0002, "status_two");
        wb_xfer(1'b0, 2'd1, 0, 32'h82AA_1234, "data_both_ch1");
        wb_xfer(1'b0, 2'd1, 0, 32'hC003_0010, "data_both_ch2");

        // empty read: zero, no underflow
        wb_xfer(1'b0, 2'd1, 0, 32'h0000_0000, "data_empty");
        wb_xfer(1'b0, 2'd0, 0, 32'h2000_0000, "status_after_empty_rd");
        wb_xfer(1'b0, 2'd2, 0, 32'h0000_0000, "ctl_reads_zero");
        wb_xfer(1'b0, 2'd3, 0, 32'h0000_0000, "reg3_reads_zero");

        // fill to DEPTH, one held in pend1, one dropped
        for (int i = 0; i < 16; i++) begin
            pulse1(10'(i), 16'(16'h1000 + i));
            idle(2);
        end
        pulse1(10'd16, 16'h1010);
        pulse1(10'd17, 16'h1011);
        idle(2);
        wb_xfer(1'b0, 2'd0, 0, 32'hC000_0010, "status_full_ovf");
        wb_xfer(1'b0, 2'd1, 0, 32'h8000_1000, "data_full_first");
        wb_xfer(1'b0, 2'd0, 0, 32'hC000_0010, "status_refilled");
        for (int i = 1; i <= 11; i++)
            wb_xfer(1'b0, 2'd1, 0, 32'h8000_0000 | (32'(i) << 16) | (32'h1000 + 32'(i)),
                    $sformatf("data_order_%0d", i));
        wb_xfer(1'b0, 2'd0, 0, 32'h8000_0005, "status_five_ovf");
        wb_xfer(1'b1, 2'd2, 32'h3, 0, "ctl_flush_clr");
        wb_xfer(1'b0, 2'd0, 0, 32'h2000_0000, "status_flushed");
        check("irq_flushed", {31'b0, irq_o}, 32'd0);

        // back-to-back pulses: a push frees pend1 as the next point lands
        for (int i = 0; i < 7; i++) begin
            ch1_rdy = 1'b1;
            ch1_d   = 10'(10'h100 + i);
            ch1_t   = 16'(i);
            idle(1);
        end
        ch1_rdy = 1'b0;
        idle(2);
        wb_xfer(1'b0, 2'd0, 0, 32'h0000_0007, "status_seven_no_ovf");
        check("irq_seven", {31'b0, irq_o}, 32'd1);

        // reset in the middle of a DATA read
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h4;
        rst_n = 1'b0;
        idle(1);
        check("midrst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("midrst_irq", {31'b0, irq_o}, 32'd0);
        rst_n = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        idle(1);
        wb_xfer(1'b0, 2'd0, 0, 32'h2000_0000, "status_after_rst");
        wb_xfer(1'b0, 2'd1, 0, 32'h0000_0000, "data_after_rst");

        idle(3);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
